// File: rtl/cnn_layer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cnn_layer_sequencer_pkg
// Shared CNN definitions: layer count, counter width, watchdog default and
// the layer-sequencer state encoding.
// ---------------------------------------------------------------------------
package cnn_layer_sequencer_pkg;

  localparam int          CNN_NUM_LAYERS      = 3;
  localparam int          CNN_CNT_W           = 32;
  localparam logic [31:0] CNN_TIMEOUT_DEFAULT = 32'd65535;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// cnn_layer_sequencer_if
// Control/status bundle between a host + three layer engines (master side)
// and the layer sequencer (slave side).
//   start, abort, pipe_mode          : run control from the host
//   l1/l2/l3_done, l1/l2_pipe_done   : progress pulses from the layer engines
//   l1/l2/l3_start                   : single-cycle start pulses to engines
//   active[2:0], busy, all_done,
//   error, cycle_count[31:0]         : status back to the host
// ---------------------------------------------------------------------------
interface cnn_layer_sequencer_if;

  logic        start;
  logic        abort;
  logic        pipe_mode;
  logic        l1_done;
  logic        l2_done;
  logic        l3_done;
  logic        l1_pipe_done;
  logic        l2_pipe_done;
  logic        l1_start;
  logic        l2_start;
  logic        l3_start;
  logic [2:0]  active;
  logic        busy;
  logic        all_done;
  logic        error;
  logic [cnn_layer_sequencer_pkg::CNN_CNT_W-1:0] cycle_count;

  modport master (
    output start, abort, pipe_mode,
    output l1_done, l2_done, l3_done, l1_pipe_done, l2_pipe_done,
    input  l1_start, l2_start, l3_start, active, busy, all_done, error,
    input  cycle_count
  );

  modport slave (
    input  start, abort, pipe_mode,
    input  l1_done, l2_done, l3_done, l1_pipe_done, l2_pipe_done,
    output l1_start, l2_start, l3_start, active, busy, all_done, error,
    output cycle_count
  );

endinterface

// File: rtl/counter_cnn.sv
// ---------------------------------------------------------------------------
// counter_cnn
// Generic saturating up-counter.
//   clk, rst  : clock, async active-high reset (count -> 0)
//   i_clear   : synchronous clear, wins over i_keep
//   i_keep    : hold the current value
//   o_count   : current count; sticks at all-ones
// ---------------------------------------------------------------------------
module counter_cnn #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_keep,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_count <= '0;
    else if (i_clear)                    r_count <= '0;
    else if (!i_keep && (r_count != '1)) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_layer_sequencer
// Schedules a 3-layer inference run. Layer 1 starts on start accept; layer
// N+1 starts after layer N reports done, or (pipelined mode) after layer N
// reports it is far enough along. A watchdog forces ERR when no progress is
// seen for TIMEOUT_CYCLES cycles. All outputs are registered.
//   clk, rst : clock, async active-high reset
//   bus      : cnn_layer_sequencer_if.slave (control in, starts/status out)
// ---------------------------------------------------------------------------
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES  = CNN_TIMEOUT_DEFAULT,
  parameter logic        PIPE_EN_DEFAULT = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  cnn_layer_sequencer_if.slave        bus
);

  seq_state_e                    r_state, nxt_state;
  logic [CNN_NUM_LAYERS-1:0]     r_lstart, nxt_lstart;
  logic [CNN_NUM_LAYERS-1:0]     r_active, nxt_active;
  logic [CNN_NUM_LAYERS-1:1]     r_started, nxt_started;  // layers 2..3 launched this run
  logic                          r_busy, r_all_done, nxt_all_done;
  logic                          r_error, nxt_error;
  logic                          r_pipe, nxt_pipe;

  logic [CNN_NUM_LAYERS-1:0]     w_done;
  logic [CNN_NUM_LAYERS-2:0]     w_pdone;
  logic [CNN_NUM_LAYERS-2:0]     w_adv;      // layer n ready to hand off to n+1
  logic                          w_start_acc;
  logic                          w_evt;      // accepted progress event
  logic                          w_timeout;
  logic [CNN_CNT_W-1:0]          w_wd_cnt;
  logic [CNN_CNT_W-1:0]          w_cycle_cnt;

  assign w_done  = {bus.l3_done, bus.l2_done, bus.l1_done};
  assign w_pdone = {bus.l2_pipe_done, bus.l1_pipe_done};
  // pipe_done only counts in pipelined mode; any input from an idle layer is dropped
  assign w_adv   = r_active[CNN_NUM_LAYERS-2:0] &
                   (w_done[CNN_NUM_LAYERS-2:0] | ({(CNN_NUM_LAYERS-1){r_pipe}} & w_pdone));
  assign w_timeout = (w_wd_cnt >= TIMEOUT_CYCLES);

  always_comb begin
    nxt_state    = r_state;
    nxt_lstart   = '0;
    nxt_active   = r_active;
    nxt_started  = r_started;
    nxt_all_done = 1'b0;
    nxt_error    = r_error;
    nxt_pipe     = r_pipe;
    w_start_acc  = 1'b0;
    w_evt        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_start_acc = 1'b1;
          nxt_state   = ST_RUN;
          nxt_lstart  = 3'b001;
          nxt_active  = 3'b001;
          nxt_started = '0;
          nxt_pipe    = bus.pipe_mode;
          nxt_error   = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          nxt_state  = ST_IDLE;
          nxt_active = '0;
        end else if (w_timeout) begin
          nxt_state  = ST_ERR;
          nxt_active = '0;
          nxt_error  = 1'b1;
        end else if (r_started[CNN_NUM_LAYERS-1] && (r_active == '0)) begin
          nxt_state    = ST_DONE;
          nxt_all_done = 1'b1;
        end else begin
          for (int n = 0; n < CNN_NUM_LAYERS; n++) begin
            if (w_done[n] && r_active[n]) begin
              nxt_active[n] = 1'b0;
              w_evt         = 1'b1;
            end
          end
          for (int n = 0; n < CNN_NUM_LAYERS-1; n++) begin
            if (w_adv[n]) w_evt = 1'b1;
            // launch each downstream layer once, whichever hand-off arrives first
            if (w_adv[n] && !r_started[n+1]) begin
              nxt_lstart[n+1]  = 1'b1;
              nxt_active[n+1]  = 1'b1;
              nxt_started[n+1] = 1'b1;
            end
          end
        end
      end
      ST_DONE: nxt_state = ST_IDLE;
      ST_ERR: begin
        // start only releases ERR; the host must issue a fresh start from IDLE
        if (bus.abort) begin
          nxt_state = ST_IDLE;
        end else if (bus.start) begin
          nxt_state = ST_IDLE;
          nxt_error = 1'b0;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lstart   <= '0;
      r_active   <= '0;
      r_started  <= '0;
      r_busy     <= 1'b0;
      r_all_done <= 1'b0;
      r_error    <= 1'b0;
      r_pipe     <= PIPE_EN_DEFAULT;
    end else begin
      r_state    <= nxt_state;
      r_lstart   <= nxt_lstart;
      r_active   <= nxt_active;
      r_started  <= nxt_started;
      r_busy     <= (nxt_state != ST_IDLE);
      r_all_done <= nxt_all_done;
      r_error    <= nxt_error;
      r_pipe     <= nxt_pipe;
    end
  end

  counter_cnn #(.WIDTH(CNN_CNT_W)) u_wd_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start_acc | w_evt),
    .i_keep  (r_state != ST_RUN),
    .o_count (w_wd_cnt)
  );

  counter_cnn #(.WIDTH(CNN_CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start_acc),
    .i_keep  (r_state != ST_RUN),
    .o_count (w_cycle_cnt)
  );

  assign bus.l1_start    = r_lstart[0];
  assign bus.l2_start    = r_lstart[1];
  assign bus.l3_start    = r_lstart[2];
  assign bus.active      = r_active;
  assign bus.busy        = r_busy;
  assign bus.all_done    = r_all_done;
  assign bus.error       = r_error;
  assign bus.cycle_count = w_cycle_cnt;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_sequencer
// Directed bench for cnn_layer_sequencer (watchdog limit 16). "Cycle c" is
// the clock period after the c-th rising edge counted from the cycle in
// which start is driven (cycle 0). Inputs for cycle c are driven and
// outputs of cycle c are sampled 1 ns after the edge that opens it.
// Output vector: {l3_start,l2_start,l1_start,active[2:0],busy,all_done,error}
// ---------------------------------------------------------------------------
module tb_cnn_layer_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;
  logic [8:0] g_vec, e_vec;
  logic [2:0] ea;

  cnn_layer_sequencer_if bus();

  cnn_layer_sequencer #(
    .TIMEOUT_CYCLES  (32'd16),
    .PIPE_EN_DEFAULT (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL tb_watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] obs();
    return {bus.l3_start, bus.l2_start, bus.l1_start, bus.active,
            bus.busy, bus.all_done, bus.error};
  endfunction

  task automatic clr_inputs();
    bus.start = 0; bus.abort = 0; bus.pipe_mode = 0;
    bus.l1_done = 0; bus.l2_done = 0; bus.l3_done = 0;
    bus.l1_pipe_done = 0; bus.l2_pipe_done = 0;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1'b1;
    #1;
    n_chk++;
    if (obs() !== 9'd0 || bus.cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_state got=%b/%0d exp=0/0", obs(), bus.cycle_count);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    n_chk++;
    if (obs() !== 9'd0) begin n_bad++; $display("FAIL reset_release got=%b exp=0", obs()); end
  endtask

  task automatic test_sequential();
    bus.pipe_mode = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      bus.start = 0;
      bus.l1_done = (c == 10); bus.l2_done = (c == 20); bus.l3_done = (c == 30);
      ea = (c <= 10) ? 3'b001 : (c <= 20) ? 3'b010 : (c <= 30) ? 3'b100 : 3'b000;
      e_vec = {c == 21, c == 11, c == 1, ea, c <= 32, c == 32, 1'b0};
      g_vec = obs();
      n_chk++;
      if (g_vec !== e_vec) begin n_bad++; $display("FAIL seq cyc=%0d got=%b exp=%b", c, g_vec, e_vec); end
    end
    n_chk++;
    if (bus.cycle_count !== 32'd31) begin
      n_bad++; $display("FAIL seq_cycle_count got=%0d exp=31", bus.cycle_count);
    end
  endtask

  task automatic test_pipelined();
    bus.pipe_mode = 1'b1; bus.start = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      tick();
      bus.start = 0; bus.pipe_mode = 0;
      bus.l1_pipe_done = (c == 5);  bus.l1_done = (c == 12);
      bus.l2_pipe_done = (c == 14); bus.l2_done = (c == 16);
      bus.l3_done      = (c == 20);
      ea = (c <= 5)  ? 3'b001 : (c <= 12) ? 3'b011 : (c <= 14) ? 3'b010 :
           (c <= 16) ? 3'b110 : (c <= 20) ? 3'b100 : 3'b000;
      e_vec = {c == 15, c == 6, c == 1, ea, c <= 22, c == 22, 1'b0};
      g_vec = obs();
      n_chk++;
      if (g_vec !== e_vec) begin n_bad++; $display("FAIL pipe cyc=%0d got=%b exp=%b", c, g_vec, e_vec); end
    end
    n_chk++;
    if (bus.cycle_count !== 32'd21) begin
      n_bad++; $display("FAIL pipe_cycle_count got=%0d exp=21", bus.cycle_count);
    end
  endtask

  task automatic test_timeout();
    bus.pipe_mode = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.start = (c == 18);
      ea = (c <= 17) ? 3'b001 : 3'b000;
      e_vec = {1'b0, 1'b0, c == 1, ea, c <= 18, 1'b0, c == 18};
      g_vec = obs();
      n_chk++;
      if (g_vec !== e_vec) begin n_bad++; $display("FAIL timeout cyc=%0d got=%b exp=%b", c, g_vec, e_vec); end
    end
    bus.start = 0;
    n_chk++;
    if (bus.cycle_count !== 32'd17) begin
      n_bad++; $display("FAIL timeout_cycle_count got=%0d exp=17", bus.cycle_count);
    end
  endtask

  task automatic test_abort();
    bus.pipe_mode = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      bus.start = (c == 10);
      bus.abort = (c == 8) || (c == 12);
      ea = ((c <= 8) || (c >= 11 && c <= 12)) ? 3'b001 : 3'b000;
      e_vec = {1'b0, 1'b0, (c == 1) || (c == 11), ea,
               (c <= 8) || (c >= 11 && c <= 12), 1'b0, 1'b0};
      g_vec = obs();
      n_chk++;
      if (g_vec !== e_vec) begin n_bad++; $display("FAIL abort cyc=%0d got=%b exp=%b", c, g_vec, e_vec); end
      if (c == 10) begin
        n_chk++;
        if (bus.cycle_count !== 32'd8) begin
          n_bad++; $display("FAIL abort_count_held got=%0d exp=8", bus.cycle_count);
        end
      end
      if (c == 11) begin
        n_chk++;
        if (bus.cycle_count !== 32'd0) begin
          n_bad++; $display("FAIL restart_count_clear got=%0d exp=0", bus.cycle_count);
        end
      end
    end
    bus.abort = 0;
  endtask

  task automatic test_ignored();
    bus.pipe_mode = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      bus.start        = (c == 3) || (c == 10);
      bus.pipe_mode    = (c == 3);
      bus.l1_pipe_done = (c == 3);
      bus.l2_done      = (c == 4);
      bus.l3_done      = (c == 4);
      bus.l1_done      = (c == 6);
      bus.l2_pipe_done = (c == 9);
      bus.abort        = (c == 14);
      ea = (c <= 6) ? 3'b001 : (c <= 14) ? 3'b010 : 3'b000;
      e_vec = {1'b0, c == 7, c == 1, ea, c <= 14, 1'b0, 1'b0};
      g_vec = obs();
      n_chk++;
      if (g_vec !== e_vec) begin n_bad++; $display("FAIL ignored cyc=%0d got=%b exp=%b", c, g_vec, e_vec); end
    end
    clr_inputs();
    n_chk++;
    if (bus.cycle_count !== 32'd14) begin
      n_bad++; $display("FAIL ignored_cycle_count got=%0d exp=14", bus.cycle_count);
    end
  endtask

  task automatic test_async_reset();
    bus.pipe_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 0;
    bus.l1_done = 1'b1;            // cycle 1: layer 2 starts at cycle 2
    tick();
    bus.l1_done = 0;
    repeat (3) tick();             // cycle 5: mid-run, count=4
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (obs() !== 9'd0 || bus.cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL async_reset got=%b/%0d exp=0/0", obs(), bus.cycle_count);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_chk++;
      if (obs() !== 9'd0) begin n_bad++; $display("FAIL post_reset cyc=%0d got=%b exp=0", c, obs()); end
    end
    bus.start = 1'b1;
    tick();
    bus.start = 0;
    n_chk++;
    if (obs() !== 9'b001_001_100) begin
      n_bad++; $display("FAIL post_reset_start got=%b exp=001001100", obs());
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 0;
    n_chk++;
    if (obs() !== 9'd0) begin n_bad++; $display("FAIL post_reset_abort got=%b exp=0", obs()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_pipelined();
    tick();
    test_timeout();
    tick();
    test_abort();
    tick();
    test_ignored();
    tick();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
